mips_cpu_bus_memctrl: RTL and testbench
=======================================

Name: mips_cpu_bus_memctrl

Overview:
- Memory-access controller between the MIPS core datapath and the Avalon-style memory bus that the CPU drives into the RAM model.
- Takes one byte/half/word load or store request from the core at a time.
- Generates a word-aligned bus read or write with byteenable, holds it across waitrequest, and returns a lane-extracted, sign- or zero-extended result.
- Flags misaligned accesses, and bus stalls longer than a limit, as errors.

Parameters:
- WAIT_LIMIT, 0: maximum waitrequest-high cycles per access before abort with error; 0 disables the limit.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  core request strobe; sampled only while busy=0.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
- busy  output  1  high whenever state != IDLE.
- resp_valid  output  1  one-cycle completion pulse.
- resp_err  output  1  valid with resp_valid: misaligned access or timeout.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- address  output  32  bus word address, equal to {req_addr[31:2],2'b00}.
- write  output  1  bus write strobe.
- read  output  1  bus read strobe.
- waitrequest  input  1  slave stall.
- writedata  output  32  bus write data.
- byteenable  output  4  lane enables; bit i covers bits [8i+7:8i].
- readdata  input  32  bus read data; valid in the cycle waitrequest=0 with read=1.

Behaviour:
- Reset values (synchronous): state=IDLE; read=0, write=0, address=0, writedata=0, byteenable=0; resp_valid=0, resp_err=0, resp_rdata=0; wait counter=0.
- Reset mid-access: bus strobes drop after that edge. No resp_valid is produced for the aborted access.
- All outputs are registered except busy, which is decoded from state.
- States: IDLE, BUS, RESP.
- IDLE to BUS: req_valid=1 at an edge, access aligned. Load the request fields, assert read or write, drive address, byteenable and writedata.
- IDLE to RESP on misalignment: half with addr[0]=1, or word with addr[1:0]!=0. No bus strobe is asserted; resp_err=1.
- BUS: strobes, address, byteenable and writedata are held constant while waitrequest=1.
- BUS to RESP: first edge with waitrequest=0. Drop the strobe. For a load, capture the extracted readdata into resp_rdata. resp_err=0.
- BUS to RESP on timeout: WAIT_LIMIT>0 and the wait counter reaches WAIT_LIMIT while waitrequest=1. Drop the strobe; resp_err=1.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. A request presented during RESP is ignored; the core must re-present it.
- Minimum latency (waitrequest=0): accept at edge E0, bus cycle E0–E1, resp_valid E1–E2. Each wait cycle adds one cycle.
- Little-endian lane mapping; n = req_addr[1:0].
  - Byte: byteenable = 1<<n; writedata = wdata[7:0] replicated to all 4 lanes.
  - Half: byteenable = 4'b0011 if addr[1]=0, else 4'b1100; writedata = wdata[15:0] replicated.
  - Word: byteenable = 4'b1111; writedata = wdata.
- Load extraction:
  - Byte: readdata[8n+7:8n].
  - Half: readdata[15:0] or readdata[31:16].
  - Result is extended to 32 bits per req_signed; word loads are unchanged.
- Wait counter: cleared on entering BUS, increments each BUS cycle with waitrequest=1, saturating.

Test Plan:
- Word load, addr 0xBFC00028, readdata=0x8C6780B8, waitrequest=0 → read=1 for exactly 1 cycle with address=0xBFC00028 and byteenable=4'hF; resp_valid 1 cycle later; resp_rdata=0x8C6780B8; resp_err=0.
- Signed byte load, addr 0x1003, readdata=0x80FF0011, 3 wait cycles → read held 4 cycles with byteenable=4'b1000; resp_rdata=0xFFFFFF80. The same load with req_signed=0 → 0x00000080.
- Half store, addr 0x2002, wdata=0x0000BEEF → write=1, address=0x2000, byteenable=4'b1100, writedata=0xBEEFBEEF; resp_rdata=0.
- Misaligned word load, addr 0x2001 → no read/write strobe; resp_valid and resp_err=1 one cycle after accept.
- WAIT_LIMIT=4, waitrequest stuck high → read asserted 4 cycles then dropped; resp_err=1.
- Reset asserted in the second wait cycle of a load → read=0 after that edge, no resp_valid; a new request after reset completes normally.
- Request held high during RESP → not accepted in RESP, accepted in the following IDLE cycle.

Source files
------------

// File: rtl/mips_cpu_bus_memctrl_if.sv
// Avalon-style memory bus between the CPU memory controller and the RAM model.
//   address     word-aligned byte address
//   read/write  transfer strobes, held until waitrequest is low
//   writedata   store data, already replicated onto the addressed lanes
//   byteenable  lane enables, bit i covers bits [8i+7:8i]
//   waitrequest slave stall
//   readdata    load data, valid in the cycle waitrequest=0 with read=1
// The master modport is the controller side; the slave modport is the memory side.
interface mips_cpu_bus_memctrl_if;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  modport master (
    output address, write, read, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, write, read, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_cpu_bus_memctrl.sv
// Memory-access controller between the MIPS core datapath and the memory bus.
// Accepts one byte/half/word load or store at a time, issues a word-aligned
// bus transfer with byteenable, holds it across waitrequest and returns the
// lane-extracted, sign- or zero-extended load result.
// Misaligned accesses and stalls reaching WAIT_LIMIT complete with resp_err.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_valid           request strobe, sampled only while busy=0
//   req_write           1 = store, 0 = load
//   req_size            0 byte, 1 half, 2/3 word
//   req_signed          loads: 1 sign-extend, 0 zero-extend
//   req_addr, req_wdata byte address, right-justified store data
//   busy                high whenever the controller is not idle
//   resp_valid          one-cycle completion pulse
//   resp_err            misaligned or timed out, valid with resp_valid
//   resp_rdata          extended load data, 0 for stores and errors
//   bus                 memory bus, master side
module mips_cpu_bus_memctrl #(
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  mips_cpu_bus_memctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t      state, state_d;
  logic        read_d, write_d;
  logic [31:0] address_d, writedata_d;
  logic [3:0]  byteenable_d;
  logic        resp_valid_d, resp_err_d;
  logic [31:0] resp_rdata_d;
  logic [31:0] wait_cnt, wait_cnt_d, wait_inc;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  off_q, off_d;
  logic        misaligned;

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    return 4'b0001 << off;
      2'd1:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'd0:    return {4{wdata[7:0]}};
      2'd1:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] lane_extract(input logic [1:0] size, input logic sgn,
                                               input logic [1:0] off, input logic [31:0] data);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = data[7:0];
      2'd1:    b = data[15:8];
      2'd2:    b = data[23:16];
      default: b = data[31:24];
    endcase
    h = off[1] ? data[31:16] : data[15:0];
    case (size)
      2'd0:    return {{24{sgn & b[7]}}, b};
      2'd1:    return {{16{sgn & h[15]}}, h};
      default: return data;
    endcase
  endfunction

  assign busy = (state != IDLE);

  // Half needs addr[0]=0; word (size 2 or 3) needs addr[1:0]=0.
  assign misaligned = (req_size == 2'd1) ? req_addr[0]
                    : (req_size[1] ? (req_addr[1:0] != 2'b00) : 1'b0);

  // Saturating increment so a disabled limit cannot wrap the counter.
  assign wait_inc = (wait_cnt == 32'hFFFF_FFFF) ? wait_cnt : wait_cnt + 32'd1;

  always_comb begin
    state_d      = state;
    read_d       = bus.read;
    write_d      = bus.write;
    address_d    = bus.address;
    writedata_d  = bus.writedata;
    byteenable_d = bus.byteenable;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err;
    resp_rdata_d = resp_rdata;
    wait_cnt_d   = wait_cnt;
    size_d       = size_q;
    signed_d     = signed_q;
    off_d        = off_q;

    case (state)
      IDLE: begin
        if (req_valid) begin
          if (misaligned) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'd0;
          end else begin
            state_d      = BUS;
            read_d       = ~req_write;
            write_d      = req_write;
            address_d    = {req_addr[31:2], 2'b00};
            writedata_d  = lane_wdata(req_size, req_wdata);
            byteenable_d = lane_be(req_size, req_addr[1:0]);
            wait_cnt_d   = 32'd0;
            size_d       = req_size;
            signed_d     = req_signed;
            off_d        = req_addr[1:0];
          end
        end
      end

      BUS: begin
        if (!bus.waitrequest) begin
          state_d      = RESP;
          read_d       = 1'b0;
          write_d      = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = bus.read ? lane_extract(size_q, signed_q, off_q, bus.readdata) : 32'd0;
        end else begin
          wait_cnt_d = wait_inc;
          // Abort on the stall cycle that brings the count up to the limit.
          if (WAIT_LIMIT != 0 && wait_inc == 32'(WAIT_LIMIT)) begin
            state_d      = RESP;
            read_d       = 1'b0;
            write_d      = 1'b0;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'd0;
          end
        end
      end

      default: begin
        // RESP: the pulse lasts one cycle; requests seen here are dropped.
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      bus.read       <= 1'b0;
      bus.write      <= 1'b0;
      bus.address    <= 32'd0;
      bus.writedata  <= 32'd0;
      bus.byteenable <= 4'd0;
      resp_valid     <= 1'b0;
      resp_err       <= 1'b0;
      resp_rdata     <= 32'd0;
      wait_cnt       <= 32'd0;
      size_q         <= 2'd0;
      signed_q       <= 1'b0;
      off_q          <= 2'd0;
    end else begin
      state          <= state_d;
      bus.read       <= read_d;
      bus.write      <= write_d;
      bus.address    <= address_d;
      bus.writedata  <= writedata_d;
      bus.byteenable <= byteenable_d;
      resp_valid     <= resp_valid_d;
      resp_err       <= resp_err_d;
      resp_rdata     <= resp_rdata_d;
      wait_cnt       <= wait_cnt_d;
      size_q         <= size_d;
      signed_q       <= signed_d;
      off_q          <= off_d;
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus_memctrl.sv
// Scoreboard bench for mips_cpu_bus_memctrl: stimulus pushes expected bus
// transfers and responses into queues; monitors pop and compare them.
module tb_mips_cpu_bus_memctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        busy, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  int          n_checks = 0;
  int          n_fail   = 0;

  int          wait_n = 0;
  int          wcnt;
  logic [31:0] mem_rdata = 32'd0;

  mips_cpu_bus_memctrl_if bif();

  mips_cpu_bus_memctrl #(.WAIT_LIMIT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .bus        (bif)
  );

  always #5 clk = ~clk;

  // Memory model: stall wait_n cycles at the start of each transfer.
  assign bif.waitrequest = (bif.read || bif.write) && (wcnt < wait_n);
  assign bif.readdata    = mem_rdata;

  always @(posedge clk) begin
    if (!(bif.read || bif.write) || !bif.waitrequest) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          cyc;
  } bus_exp_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } resp_exp_t;

  bus_exp_t  bus_q[$];
  resp_exp_t resp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Response monitor
  initial begin
    resp_exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && resp_valid === 1'b1) begin
        if (resp_q.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = resp_q.pop_front();
          check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
          check("resp_rdata", resp_rdata, e.rdata);
        end
      end
    end
  end

  // Bus monitor: one record per strobe burst, fields must stay stable.
  initial begin
    bus_exp_t    e;
    logic        in_txn;
    int          cyc;
    logic        f_wr;
    logic [31:0] f_addr, f_wd;
    logic [3:0]  f_be;
    in_txn = 1'b0;
    cyc    = 0;
    forever begin
      @(negedge clk);
      if (bif.read === 1'b1 || bif.write === 1'b1) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          cyc    = 1;
          f_wr   = bif.write;
          f_addr = bif.address;
          f_wd   = bif.writedata;
          f_be   = bif.byteenable;
        end else begin
          cyc++;
          check("bus_hold", {bif.write, bif.byteenable, bif.address[26:0]},
                {f_wr, f_be, f_addr[26:0]});
        end
      end else if (in_txn) begin
        in_txn = 1'b0;
        if (bus_q.size() == 0) begin
          check("unexpected_bus", 32'd1, 32'd0);
        end else begin
          e = bus_q.pop_front();
          check("bus_write", {31'd0, f_wr}, {31'd0, e.wr});
          check("bus_address", f_addr, e.addr);
          check("bus_byteenable", {28'd0, f_be}, {28'd0, e.be});
          if (e.wr) check("bus_writedata", f_wd, e.wd);
          check("bus_cycles", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (!busy) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_idle: busy still 1 after 100 cycles, expected 0");
  endtask

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, input logic [31:0] rd,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        input logic exp_bus, input logic [31:0] exp_addr,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input int exp_cyc);
    bus_exp_t  b;
    resp_exp_t r;
    @(negedge clk);
    wait_n     = waits;
    mem_rdata  = rd;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    if (exp_bus) begin
      b.wr = wr; b.addr = exp_addr; b.be = exp_be; b.wd = exp_wd; b.cyc = exp_cyc;
      bus_q.push_back(b);
    end
    r.err = exp_err; r.rdata = exp_rdata;
    resp_q.push_back(r);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_exp_t  b;
    resp_exp_t r;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_strobes", {30'd0, bif.read, bif.write}, 32'd0);
    check("rst_address", bif.address, 32'd0);
    check("rst_byteenable", {28'd0, bif.byteenable}, 32'd0);
    check("rst_resp", {31'd0, resp_valid}, 32'd0);
    reset = 1'b0;

    //     wr    sz    sg    addr          wdata         waits rd            err   rdata         bus   baddr         be       wd            cyc
    do_req(1'b0, 2'd2, 1'b0, 32'hBFC00028, 32'h0,       0,    32'h8C6780B8, 1'b0, 32'h8C6780B8, 1'b1, 32'hBFC00028, 4'hF,    32'h0,        1);
    do_req(1'b0, 2'd0, 1'b1, 32'h00001003, 32'h0,       3,    32'h80FF0011, 1'b0, 32'hFFFFFF80, 1'b1, 32'h00001000, 4'b1000, 32'h0,        4);
    do_req(1'b0, 2'd0, 1'b0, 32'h00001003, 32'h0,       3,    32'h80FF0011, 1'b0, 32'h00000080, 1'b1, 32'h00001000, 4'b1000, 32'h0,        4);
    do_req(1'b1, 2'd1, 1'b0, 32'h00002002, 32'h0000BEEF,0,    32'h12345678, 1'b0, 32'h00000000, 1'b1, 32'h00002000, 4'b1100, 32'hBEEFBEEF, 1);
    do_req(1'b0, 2'd2, 1'b0, 32'h00002001, 32'h0,       0,    32'h12345678, 1'b1, 32'h00000000, 1'b0, 32'h0,        4'h0,    32'h0,        0);
    do_req(1'b0, 2'd1, 1'b0, 32'h00000003, 32'h0,       0,    32'h12345678, 1'b1, 32'h00000000, 1'b0, 32'h0,        4'h0,    32'h0,        0);
    do_req(1'b0, 2'd2, 1'b0, 32'h00000040, 32'h0,       100,  32'h12345678, 1'b1, 32'h00000000, 1'b1, 32'h00000040, 4'hF,    32'h0,        4);
    do_req(1'b1, 2'd0, 1'b0, 32'h00000041, 32'h12345678,0,    32'h0,        1'b0, 32'h00000000, 1'b1, 32'h00000040, 4'b0010, 32'h78787878, 1);
    do_req(1'b0, 2'd1, 1'b1, 32'h00000102, 32'h0,       1,    32'h80017FFF, 1'b0, 32'hFFFF8001, 1'b1, 32'h00000100, 4'b1100, 32'h0,        2);
    do_req(1'b0, 2'd1, 1'b1, 32'h00000100, 32'h0,       0,    32'h80017FFF, 1'b0, 32'h00007FFF, 1'b1, 32'h00000100, 4'b0011, 32'h0,        1);
    do_req(1'b1, 2'd2, 1'b0, 32'h00000044, 32'hDEADBEEF,2,    32'h0,        1'b0, 32'h00000000, 1'b1, 32'h00000044, 4'hF,    32'hDEADBEEF, 3);
    do_req(1'b0, 2'd3, 1'b1, 32'h00000008, 32'h0,       0,    32'h11223344, 1'b0, 32'h11223344, 1'b1, 32'h00000008, 4'hF,    32'h0,        1);
    do_req(1'b0, 2'd0, 1'b1, 32'h00000002, 32'h0,       0,    32'h00C30000, 1'b0, 32'hFFFFFFC3, 1'b1, 32'h00000000, 4'b0100, 32'h0,        1);

    // Reset in the second stall cycle: strobe drops, no response.
    @(negedge clk);
    wait_n     = 10;
    req_write  = 1'b0;
    req_size   = 2'd2;
    req_signed = 1'b0;
    req_addr   = 32'h00000500;
    req_valid  = 1'b1;
    b.wr = 1'b0; b.addr = 32'h00000500; b.be = 4'hF; b.wd = 32'h0; b.cyc = 2;
    bus_q.push_back(b);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_read", {31'd0, bif.read}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    repeat (3) @(posedge clk);

    // Request held through RESP: second acceptance only once back in IDLE.
    @(negedge clk);
    wait_n    = 0;
    mem_rdata = 32'hCAFEF00D;
    req_write = 1'b0;
    req_size  = 2'd2;
    req_addr  = 32'h00003000;
    req_valid = 1'b1;
    b.wr = 1'b0; b.addr = 32'h00003000; b.be = 4'hF; b.wd = 32'h0; b.cyc = 1;
    bus_q.push_back(b);
    bus_q.push_back(b);
    r.err = 1'b0; r.rdata = 32'hCAFEF00D;
    resp_q.push_back(r);
    resp_q.push_back(r);
    @(posedge clk);
    #1;
    check("hold_first_read", {31'd0, bif.read}, 32'd1);
    @(posedge clk);
    #1;
    check("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
    check("hold_resp_no_read", {31'd0, bif.read}, 32'd0);
    @(posedge clk);
    #1;
    check("hold_idle_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check("hold_second_read", {31'd0, bif.read}, 32'd1);
    req_valid = 1'b0;
    wait_idle();

    repeat (4) @(posedge clk);
    check("bus_queue_empty", 32'(bus_q.size()), 32'd0);
    check("resp_queue_empty", 32'(resp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
